// File: rtl/keccak_assemble_pkg.sv
// Shared definitions for the Keccak message-block assembler:
// default block geometry, word-index width and FSM state encoding.
package keccak_assemble_pkg;

  localparam int WORDS_DEF = 16;   // 32-bit words per message block
  localparam int BLOCK_W   = 512;  // assembled block width in bits
  localparam int IDX_W     = 6;    // width of the word-index port
  localparam int CNT_W     = 5;    // width of the written-word counter

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } asm_state_t;

endpackage

// File: rtl/keccak_assemble_popcnt16.sv
// Population count of a 16-bit written-word mask.
module keccak_popcnt16
  import keccak_assemble_pkg::*;
(
  input  logic [15:0]      i_bits,
  output logic [CNT_W-1:0] o_cnt
);

  // Sum of set bits; the result is at most 16 and fits in CNT_W bits.
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      o_cnt = o_cnt + CNT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/keccak_assemble.sv
// Keccak message-block assembler.
// Collects WORDS 32-bit words written by index into one block, presents the
// block with a valid/ready handshake and flags protocol errors (out-of-range
// index, or a write while the block is waiting to be taken).
// Optional build macro: KECCAK_ASSEMBLE_BYTESWAP_EN -- byte-reverse each
// incoming word before storage to match little-endian Keccak lane order.
module keccak_assemble
  import keccak_assemble_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [IDX_W-1:0]      num,
  input  logic [31:0]           in32,
  input  logic                  clr,
  output logic [32*WORDS-1:0]   out512,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      word_cnt,
  output logic                  busy,
  output logic                  err
);

  // Index bits needed to address a word slot; num above this is range-checked.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

`ifdef KECCAK_ASSEMBLE_BYTESWAP_EN
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
`endif

  asm_state_t                  r_state;
  asm_state_t                  w_state_nxt;
  logic [WORDS-1:0]            r_mask;
  logic [WORDS-1:0]            w_mask_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic                        r_err;
  logic                        w_err_nxt;
  logic                        w_wr;
  logic                        w_num_ok;
  logic [IW-1:0]               w_idx;
  logic [31:0]                 w_word;
  logic [15:0]                 w_pc_in;
  logic [WORDS-1:0][31:0]      r_data;

  assign w_num_ok = (num < IDX_W'(WORDS));
  assign w_idx    = num[IW-1:0];

`ifdef KECCAK_ASSEMBLE_BYTESWAP_EN
  assign w_word = swap_bytes(in32);
`else
  assign w_word = in32;
`endif

  // Next-state, next-mask, error and data-write decode; clr wins over
  // everything except reset, and a write during FULL only raises err.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_err_nxt   = r_err;
    w_wr        = 1'b0;
    if (clr) begin
      w_state_nxt = ST_FILL;
      w_mask_nxt  = '0;
      w_err_nxt   = 1'b0;
    end else begin
      if (en && !w_num_ok) begin
        w_err_nxt = 1'b1;
      end
      case (r_state)
        ST_FILL: begin
          if (en && w_num_ok) begin
            w_wr              = 1'b1;
            w_mask_nxt[w_idx] = 1'b1;
            if (&w_mask_nxt) begin
              w_state_nxt = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (en) begin
            w_err_nxt = 1'b1;
          end
          if (out_ready) begin
            w_state_nxt = ST_FILL;
            w_mask_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_FILL;
          w_mask_nxt  = '0;
        end
      endcase
    end
  end

  // The counter is computed from the next mask so it changes on the same
  // edge as the mask itself.
  always_comb begin
    w_pc_in            = '0;
    w_pc_in[WORDS-1:0] = w_mask_nxt;
  end

  keccak_popcnt16 u_popcnt (
    .i_bits (w_pc_in),
    .o_cnt  (w_cnt_nxt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control registers: written-word mask, its popcount, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_mask <= w_mask_nxt;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Block storage; contents survive a transfer and clr, only reset zeroes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_wr) begin
      r_data[w_idx] <= w_word;
    end
  end

  assign out512    = r_data;
  assign out_valid = (r_state == ST_FULL);
  assign word_cnt  = r_cnt;
  assign busy      = out_valid | (r_cnt != '0);
  assign err       = r_err;

endmodule

// File: tb/tb_keccak_assemble.sv
// Scoreboard bench for keccak_assemble: stimulus queues expected output
// values tagged with the cycle they apply to; a negedge monitor pops and
// compares them against the DUT.
module tb_keccak_assemble;

  localparam int K_VLD  = 0;
  localparam int K_CNT  = 1;
  localparam int K_ERR  = 2;
  localparam int K_BUSY = 3;
  localparam int K_BLK  = 4;
  localparam int K_WORD = 5;

  typedef struct {
    int           cyc;
    int           kind;
    int           idx;
    logic [511:0] val;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [5:0]   num;
  logic [31:0]  in32;
  logic         clr;
  logic [511:0] out512;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   word_cnt;
  logic         busy;
  logic         err;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fails = 0;
  exp_t         q[$];
  logic [15:0][31:0] m_blk;

  keccak_assemble #(.WORDS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .num       (num),
    .in32      (in32),
    .clr       (clr),
    .out512    (out512),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Value the block is expected to hold after writing x.
  function automatic logic [31:0] st(input logic [31:0] x);
`ifdef KECCAK_ASSEMBLE_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input int idx, input logic [511:0] val, input string tag);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    e.tag  = tag;
    q.push_back(e);
  endtask

  // Standard set of output expectations for the current cycle.
  task automatic expect_all(input logic vld, input int cnt, input logic er, input string tag);
    expect_v(K_VLD,  0, 512'(vld), {tag, ".vld"});
    expect_v(K_CNT,  0, 512'(cnt), {tag, ".cnt"});
    expect_v(K_ERR,  0, 512'(er),  {tag, ".err"});
    expect_v(K_BUSY, 0, 512'(vld || (cnt != 0)), {tag, ".busy"});
    expect_v(K_BLK,  0, 512'(m_blk), {tag, ".blk"});
  endtask

  task automatic wr(input int n, input logic [31:0] d);
    en   = 1'b1;
    num  = 6'(n);
    in32 = d;
    step();
    en   = 1'b0;
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t         e;
    logic [511:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = '0;
      case (e.kind)
        K_VLD:   act = 512'(out_valid);
        K_CNT:   act = 512'(word_cnt);
        K_ERR:   act = 512'(err);
        K_BUSY:  act = 512'(busy);
        K_BLK:   act = out512;
        default: act = 512'(out512[32*e.idx +: 32]);
      endcase
      n_checks++;
      if (e.cyc != cyc) begin
        n_fails++;
        $display("FAIL %s: stale expectation (cycle %0d seen at %0d)", e.tag, e.cyc, cyc);
      end else if (act !== e.val) begin
        n_fails++;
        $display("FAIL %s: got %h expected %h", e.tag, act, e.val);
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; num = '0; in32 = '0; clr = 1'b0; out_ready = 1'b0;
    m_blk = '0;
    step(); step();
    reset = 1'b0;
    step();
    expect_all(1'b0, 0, 1'b0, "reset");

    // Index just past the end: no write, error raised.
    wr(16, 32'hDEAD_BEEF);
    expect_all(1'b0, 0, 1'b1, "num16");
    clr = 1'b1; step(); clr = 1'b0;
    expect_all(1'b0, 0, 1'b0, "num16_clr");

    // Full block in order; valid only after the 16th write.
    for (int k = 0; k < 16; k++) begin
      wr(k, 32'h1000_0000 + k);
      m_blk[k] = st(32'h1000_0000 + k);
      if (k == 14) expect_all(1'b0, 15, 1'b0, "fill15");
    end
    expect_all(1'b1, 16, 1'b0, "fill16");
    expect_v(K_WORD, 7, 512'(st(32'h1000_0007)), "fill16.w7");
    step();
    expect_all(1'b1, 16, 1'b0, "hold");

    // Single-cycle handshake.
    out_ready = 1'b1; step(); out_ready = 1'b0;
    expect_all(1'b0, 0, 1'b0, "xfer");

    // Rewrite word 3, then words 0..2.
    wr(3, 32'hAAAA_AAAA);
    m_blk[3] = st(32'hAAAA_AAAA);
    wr(3, 32'h5555_5555);
    m_blk[3] = st(32'h5555_5555);
    expect_all(1'b0, 1, 1'b0, "rewrite");
    for (int k = 0; k < 3; k++) begin
      wr(k, 32'h2000_0000 + k);
      m_blk[k] = st(32'h2000_0000 + k);
    end
    expect_all(1'b0, 4, 1'b0, "w0to3");
    expect_v(K_WORD, 3, 512'(st(32'h5555_5555)), "w0to3.w3");

    // Out-of-range write: err only, data and mask untouched.
    wr(20, 32'hDEAD_BEEF);
    expect_all(1'b0, 4, 1'b1, "num20");
    clr = 1'b1; step(); clr = 1'b0;
    expect_all(1'b0, 0, 1'b0, "clr1");

    // Write while FULL: ignored, err raised.
    for (int k = 0; k < 16; k++) begin
      wr(k, 32'h3000_0000 + k);
      m_blk[k] = st(32'h3000_0000 + k);
    end
    expect_all(1'b1, 16, 1'b0, "full2");
    wr(5, 32'hFFFF_FFFF);
    expect_all(1'b1, 16, 1'b1, "wr_full");
    clr = 1'b1; step(); clr = 1'b0;
    expect_all(1'b0, 0, 1'b0, "clr2");

    // clr together with handshake while FULL.
    for (int k = 0; k < 16; k++) begin
      wr(k, 32'h4000_0000 + k);
      m_blk[k] = st(32'h4000_0000 + k);
    end
    expect_all(1'b1, 16, 1'b0, "full3");
    clr = 1'b1; out_ready = 1'b1; step(); clr = 1'b0; out_ready = 1'b0;
    expect_all(1'b0, 0, 1'b0, "clr_rdy");
    wr(0, 32'h4444_0000);
    m_blk[0] = st(32'h4444_0000);
    expect_all(1'b0, 1, 1'b0, "fill_after_clr");

    // en coinciding with handshake: transfer happens, write ignored, err set.
    for (int k = 1; k < 16; k++) begin
      wr(k, 32'h5000_0000 + k);
      m_blk[k] = st(32'h5000_0000 + k);
    end
    expect_all(1'b1, 16, 1'b0, "full4");
    en = 1'b1; num = 6'd2; in32 = 32'h0BAD_0BAD; out_ready = 1'b1;
    step();
    en = 1'b0; out_ready = 1'b0;
    expect_all(1'b0, 0, 1'b1, "en_xfer");
    clr = 1'b1; step(); clr = 1'b0;
    expect_all(1'b0, 0, 1'b0, "clr3");

    // Reset mid-fill overrides a concurrent write.
    for (int k = 0; k < 7; k++) begin
      wr(k, 32'h6000_0000 + k);
      m_blk[k] = st(32'h6000_0000 + k);
    end
    expect_all(1'b0, 7, 1'b0, "fill7");
    reset = 1'b1; en = 1'b1; num = 6'd9; in32 = 32'h1234_5678;
    step();
    reset = 1'b0; en = 1'b0;
    m_blk = '0;
    expect_all(1'b0, 0, 1'b0, "reset_mid");

`ifdef KECCAK_ASSEMBLE_BYTESWAP_EN
    wr(0, 32'h0102_0304);
    expect_v(K_WORD, 0, 512'(32'h0403_0201), "bswap.w0");
    expect_v(K_CNT,  0, 512'(1), "bswap.cnt");
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/keccak_assemble.md
KECCAK_ASSEMBLE -- requirements
Module: keccak_assemble

Interface
REQ-001 SHALL provide parameter WORDS, default 16, the number of 32-bit words per message block; out512 width is 32*WORDS.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port en  input  1  word-write strobe from custom-instruction decode.
REQ-005 SHALL provide port num  input  6  word index (cust5_limm); valid range 0..WORDS-1.
REQ-006 SHALL provide port in32  input  32  word data.
REQ-007 SHALL provide port clr  input  1  discards the partial block and clears the error.
REQ-008 SHALL provide port out512  output  512  assembled block to keccak_ctrl; word k at bits [32k+31:32k].
REQ-009 SHALL provide port out_valid  output  1  block complete and held stable.
REQ-010 SHALL provide port out_ready  input  1  keccak_ctrl accepts the block.
REQ-011 SHALL provide port word_cnt  output  5  number of distinct words written in the current block.
REQ-012 SHALL provide port busy  output  1  high when out_valid=1 or word_cnt!=0.
REQ-013 SHALL provide port err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL implement a two-state FSM: FILL and FULL.
REQ-015 In FILL, en=1 with num<WORDS SHALL write in32 into word num and set mask bit num on the same edge.
REQ-016 A rewrite of an already-written word SHALL overwrite the data and leave mask and word_cnt unchanged.
REQ-017 word_cnt SHALL equal the popcount of the WORDS-bit mask, registered.
REQ-018 When a write completes the mask (all ones), the FSM SHALL enter FULL and out_valid SHALL be 1 from the next cycle, i.e. 1-cycle latency.
REQ-019 In FULL, out512 SHALL be held stable, and en SHALL be ignored for data while setting err.
REQ-020 In FULL, out_valid&&out_ready SHALL complete the transfer: mask cleared, out_valid=0, FSM back to FILL on the next cycle; out512 contents are retained, not zeroed.
REQ-021 out_valid SHALL NOT depend combinationally on out_ready; once high, it stays high until the transfer or clr.
REQ-022 en=1 with num>=WORDS SHALL write nothing and SHALL set err, in either state.
REQ-023 clr=1 SHALL clear mask, word_cnt, out_valid and err, and force FILL; clr SHALL take priority over en and over a simultaneous handshake, which is then not counted as a transfer.
REQ-024 en=1 in the same cycle as a FULL handshake SHALL be treated as a FULL-state write, i.e. ignored with err set.

Reset
REQ-025 On reset=1 at a clock edge, the block SHALL set state=FILL, mask=0, word_cnt=0, out512=0, out_valid=0 and err=0.
REQ-026 Reset SHALL override clr, en and the handshake, including during FULL.

Configuration
REQ-027 With KECCAK_ASSEMBLE_BYTESWAP_EN defined, each in32 SHALL be byte-reversed before storage ({b0,b1,b2,b3}), to match the little-endian Keccak lane order.
REQ-028 Without KECCAK_ASSEMBLE_BYTESWAP_EN, in32 SHALL be stored unmodified.

Structure
REQ-029 The keccak shared package SHALL hold the WORDS default (16), the block width (512), the FSM state encoding, and the word-index width (6).
REQ-030 The popcount of the mask SHALL be a sub-module named keccak_popcnt16; everything else is flat.

Verification
REQ-031 The bench SHALL cover: write words 0..15 with value 32'h1000_0000+k in order, out_ready=0 -> out_valid=1 exactly one cycle after the 16th write, word_cnt=16, and out512[32k+31:32k]=32'h1000_0000+k.
REQ-032 The bench SHALL cover: in FULL, assert out_ready for one cycle -> next cycle out_valid=0, word_cnt=0, and out512 unchanged.
REQ-033 The bench SHALL cover: write word 3 twice (32'hAAAA_AAAA, then 32'h5555_5555) plus words 0..2 -> word_cnt=4, word 3=32'h5555_5555, and err=0.
REQ-034 The bench SHALL cover: en with num=20, then en while FULL -> err=1, and neither stored data nor mask changes; clr -> err=0, word_cnt=0.
REQ-035 The bench SHALL cover: clr and out_ready both high while FULL -> out_valid=0 and state FILL, with no transfer counted; reset asserted mid-fill (word_cnt=7) -> every output takes its reset value on the next cycle.
REQ-036 The bench SHALL cover: with KECCAK_ASSEMBLE_BYTESWAP_EN defined, write 32'h0102_0304 to word 0 -> out512[31:0]=32'h0403_0201.
